keypad_scan: RTL and testbench

- Scans a 4x4 membrane keypad. Drives one row low at a time, samples the four column lines and debounces the hit.
- Emits a one-cycle key_valid strobe with a 4-bit key code; key_down stays high while the key is held.
- This is the input-side counterpart of the matrix-driving display logic: it reads a scanned matrix instead of writing one.
- Sits beside the top-level state machine and supplies numeric entry (e.g. hatch temperature, restart) in place of the single debounced button.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_tick.sv | 26 ++
 rtl/keypad_scan.sv | 176 +++++++++++++++++
 tb/tb_keypad_scan.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   state_t     : scanner FSM states (2-bit encoding)
//   NUM_ROWS, NUM_COLS, KEY_W : matrix geometry and key code width
//   lowest_low  : index of the lowest active-low column in a sample
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  // Scans from the top down so the lowest pulled-low column is the one kept.
  function automatic logic [1:0] lowest_low(input logic [NUM_COLS-1:0] c);
    lowest_low = 2'd0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!c[i]) lowest_low = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_tick.sv
// keypad_tick: free-running row-dwell divider.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   tick  out high for one cycle, on the last cycle of every SCAN_DIV-cycle dwell
module keypad_tick #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           div <= '0;
    else if (div == LAST) div <= '0;
    else                  div <= div + 1'b1;
  end

  assign tick = (div == LAST);

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 membrane keypad scanner with press/release debounce.
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   col       in  column lines, active-low (pulled up externally)
//   row       out row drive, one-hot active-low, registered
//   key_code  out last accepted key, 4*row + col
//   key_valid out one-cycle strobe per accepted key (and per repeat)
//   key_down  out high from acceptance until the release is debounced
// Optional build macro KEYPAD_REPEAT_EN: while a key stays held, re-strobe
// key_valid every REP_TICKS column samples.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_CNT   = 20,
  parameter int REP_TICKS = 500
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_COLS-1:0] col,
  output logic [NUM_ROWS-1:0] row,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_down
);

  if (SCAN_DIV < 1 || DEB_CNT < 1 || REP_TICKS < 1) begin : g_bad_param
    $error("keypad_scan: SCAN_DIV, DEB_CNT and REP_TICKS must all be >= 1");
  end

  localparam int DW = $clog2(DEB_CNT + 1);
  // Counters compare against the last value before terminal so the
  // terminal-sample decision is made on the same tick that carries it.
  localparam logic [DW-1:0] DEB_TERM = DW'(DEB_CNT - 1);

  logic tick;

  keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  state_t          state, state_n;
  logic [1:0]      row_idx, row_idx_n;
  logic [1:0]      col_idx, col_idx_n;
  logic [DW-1:0]   deb_cnt, deb_n;
  logic [DW-1:0]   rel_cnt, rel_n;
  logic [KEY_W-1:0] code_n;
  logic            valid_n, down_n, accept;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REP_TICKS + 1);
  localparam logic [RW-1:0] REP_TERM = RW'(REP_TICKS - 1);
  logic [RW-1:0] rep_cnt, rep_n;
`endif

  always_comb begin
    state_n   = state;
    row_idx_n = row_idx;
    col_idx_n = col_idx;
    deb_n     = deb_cnt;
    rel_n     = rel_cnt;
    code_n    = key_code;
    valid_n   = 1'b0;
    down_n    = key_down;
    accept    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_n     = rep_cnt;
`endif

    case (state)
      SCAN: begin
        if (tick) begin
          if (col == 4'hF) begin
            row_idx_n = row_idx + 2'd1;
          end else begin
            col_idx_n = lowest_low(col);
            if (DEB_CNT <= 1) begin
              accept = 1'b1;
            end else begin
              deb_n   = DW'(1);
              state_n = DEBOUNCE;
            end
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (!col[col_idx]) begin
            if (deb_cnt == DEB_TERM) accept = 1'b1;
            else                     deb_n  = deb_cnt + 1'b1;
          end else begin
            // Bounce: give up on this row and keep scanning.
            deb_n     = '0;
            state_n   = SCAN;
            row_idx_n = row_idx + 2'd1;
          end
        end
      end

      PRESSED: begin
        // Only the captured column is watched; row_idx stays frozen so
        // other rows are not driven and cannot interfere.
        if (tick) begin
          if (col[col_idx]) begin
            if (rel_cnt == DEB_TERM) begin
              rel_n     = '0;
              down_n    = 1'b0;
              state_n   = SCAN;
              row_idx_n = row_idx + 2'd1;
            end else begin
              rel_n = rel_cnt + 1'b1;
            end
          end else begin
            rel_n = '0;
`ifdef KEYPAD_REPEAT_EN
            if (rep_cnt == REP_TERM) begin
              rep_n   = '0;
              valid_n = !key_valid;
            end else begin
              rep_n = rep_cnt + 1'b1;
            end
`endif
          end
        end
      end

      default: state_n = SCAN;
    endcase

    if (accept) begin
      code_n  = {row_idx, col_idx_n};
      valid_n = 1'b1;
      down_n  = 1'b1;
      deb_n   = '0;
      rel_n   = '0;
      state_n = PRESSED;
`ifdef KEYPAD_REPEAT_EN
      rep_n   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      row       <= 4'b1110;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_n;
      row_idx   <= row_idx_n;
      col_idx   <= col_idx_n;
      deb_cnt   <= deb_n;
      rel_cnt   <= rel_n;
      row       <= ~(4'b0001 << row_idx_n);
      key_code  <= code_n;
      key_valid <= valid_n;
      key_down  <= down_n;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_n;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with SCAN_DIV=4, DEB_CNT=3,
// REP_TICKS=5. A behavioural 4x4 switch matrix drives col from row and the
// set of held keys.
module tb_keypad_scan;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_CNT   = 3;
  localparam int REP_TICKS = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [15:0] keys;

  keypad_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .DEB_CNT   (DEB_CNT),
    .REP_TICKS (REP_TICKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // Switch matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys[4*r+c]) col[c] = 1'b0;
  end

  int checks = 0;
  int passed = 0;
  int pulses = 0;
  int cyc = 0;
  int last_cyc = 0;
  int last_gap = 0;
  logic prev_kv = 1'b0;

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  code;
    int          hold;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [3:0] row_of(input int r);
    logic [1:0] ri;
    ri = r[1:0];
    row_of = ~(4'b0001 << ri);
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
    if (key_valid) begin
      if (pulses > 0) last_gap = cyc - last_cyc;
      last_cyc = cyc;
      pulses++;
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (pulses == 0 && n < 200) begin step(); n++; end
    chk(name, pulses, 1);
  endtask

  // Leave the caller on the first cycle of row r's dwell.
  task automatic wait_row(input int r);
    int n = 0;
    while (row == row_of(r) && n < 50) begin step(); n++; end
    while (row != row_of(r) && n < 50) begin step(); n++; end
    chk("wait_row", row, row_of(r));
  endtask

  // key_valid must never be high on two consecutive cycles.
  always @(negedge clk) begin
    if (key_valid) chk("kv_single_cycle", prev_kv, 0);
    prev_kv = key_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_pulses;
    int r;

    vecs[0] = '{16'h0040, 4'd6,  2};
    vecs[1] = '{16'h0005, 4'd0,  3};   // keys 0 and 2: column 0 wins
    vecs[2] = '{16'h8000, 4'd15, 1};
    vecs[3] = '{16'h0200, 4'd9,  2};
    vecs[4] = '{16'h6000, 4'd13, 2};   // keys 13 and 14: column 1 wins
    vecs[5] = '{16'h0040, 4'd6,  12};  // long hold for repeat behaviour

    rst_n = 1'b0;
    keys  = '0;
    repeat (3) @(negedge clk);
    chk("rst_row", row, 4'b1110);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_down", key_down, 0);
    chk("rst_key_code", key_code, 0);
    rst_n = 1'b1;

    // Idle scan: each row dwells SCAN_DIV cycles, in order, no strobes.
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("idle_row_%0d", i), row, row_of((i / SCAN_DIV) % 4));
      step();
    end
    chk("idle_no_valid", pulses, 0);

    // Table: press, hold, release.
    for (int v = 0; v < 6; v++) begin
      r = int'(vecs[v].code[3:2]);
      pulses = 0;
      keys = vecs[v].mask;
      wait_valid($sformatf("v%0d_accept", v));
      chk($sformatf("v%0d_code", v), key_code, vecs[v].code);
      chk($sformatf("v%0d_down", v), key_down, 1);
      chk($sformatf("v%0d_row_frozen", v), row, row_of(r));
      repeat (vecs[v].hold * SCAN_DIV) step();
      chk($sformatf("v%0d_row_hold", v), row, row_of(r));
      chk($sformatf("v%0d_down_hold", v), key_down, 1);
      keys = '0;
      n = 0;
      while (key_down && n < 100) begin step(); n++; end
      chk($sformatf("v%0d_released", v), key_down, 0);
      chk($sformatf("v%0d_next_row", v), row, row_of(r + 1));
      chk($sformatf("v%0d_code_kept", v), key_code, vecs[v].code);
`ifdef KEYPAD_REPEAT_EN
      exp_pulses = 1 + vecs[v].hold / REP_TICKS;
`else
      exp_pulses = 1;
`endif
      chk($sformatf("v%0d_pulses", v), pulses, exp_pulses);
      if (exp_pulses >= 2)
        chk($sformatf("v%0d_repeat_gap", v), last_gap, REP_TICKS * SCAN_DIV);
    end

    // Release with a glitch: high 2 ticks, low 1, high 3.
    pulses = 0;
    keys = 16'h0040;
    wait_valid("glitch_accept");
    keys = '0;
    repeat (2 * SCAN_DIV) step();
    chk("glitch_down_after_2hi", key_down, 1);
    keys = 16'h0040;
    repeat (SCAN_DIV) step();
    keys = '0;
    repeat (2 * SCAN_DIV) step();
    chk("glitch_down_after_lo_2hi", key_down, 1);
    repeat (SCAN_DIV) step();
    chk("glitch_down_after_3hi", key_down, 0);
    chk("glitch_next_row", row, 4'b1011);

    // Bounce: one low sample then high.
    wait_row(1);
    pulses = 0;
    keys = 16'h0040;
    repeat (SCAN_DIV) step();
    chk("bounce_row_frozen", row, 4'b1101);
    keys = '0;
    repeat (SCAN_DIV) step();
    chk("bounce_row_advance", row, 4'b1011);
    chk("bounce_no_valid", pulses, 0);
    chk("bounce_no_down", key_down, 0);

    // Asynchronous reset in the middle of DEBOUNCE.
    wait_row(1);
    keys = 16'h0040;
    repeat (SCAN_DIV + 2) step();
    chk("mid_deb_row_frozen", row, 4'b1101);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_row", row, 4'b1110);
    chk("async_rst_key_valid", key_valid, 0);
    chk("async_rst_key_down", key_down, 0);
    chk("async_rst_key_code", key_code, 0);
    keys = '0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("restart_row0", row, 4'b1110);
    repeat (SCAN_DIV) step();
    chk("restart_row1", row, 4'b1101);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
